// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants, default parameters and the frame check
package ps2_pkg;
  localparam int FRAME_LEN = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_TIMEOUT_CYC = 50000;
  function automatic logic frame_ok(input logic [FRAME_LEN-1:0] f);
    return f[0] == START_BIT && f[FRAME_LEN-1] == STOP_BIT && ^f[FRAME_LEN-2:1];
  endfunction
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: scan-code buffer with wrap-bit pointers and full/empty flags
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic rd_do, wr_do;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign rd_do = rd_en && !empty;
  assign wr_do = wr_en && (!full || rd_do);
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage and pointer update; a write into a full buffer is allowed only alongside a pop
  always_ff @(posedge clk)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_do) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_do) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard frame receiver feeding a scan-code FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0] sync;
  logic [FRAME_LEN-2:0] shreg;
  logic [FRAME_LEN-1:0] frame;
  logic [3:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic fall, done, valid, wr, empty, full, pop;
  assign fall = sync[2] & ~sync[1];
  assign frame = {ps2_data, shreg};
  assign done = fall && bit_cnt == 4'(FRAME_LEN - 1);
  assign valid = frame_ok(frame);
  assign wr = done & valid;
  assign pop = ~nextdata_n & ~empty;
  assign ready = ~empty;
  // synchronizer, bit shifting, frame counting and partial-frame timeout
  always_ff @(posedge clk)
    if (!resetn) begin
      sync <= 3'b111;
      shreg <= '0;
      bit_cnt <= '0;
      to_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[1:0], ps2_clk};
      frame_err <= done & ~valid;
      if (fall) begin
        shreg <= frame[FRAME_LEN-1:1];
        bit_cnt <= done ? '0 : bit_cnt + 4'd1;
        to_cnt <= '0;
      end else if (bit_cnt == '0) to_cnt <= '0;
      else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt <= '0;
        to_cnt <= '0;
      end else to_cnt <= to_cnt + 1'b1;
    end
  // sticky overflow: set on a dropped byte, cleared by a pop, set wins
  always_ff @(posedge clk)
    if (!resetn) overflow <= 1'b0;
    else if (wr && full && !pop) overflow <= 1'b1;
    else if (pop) overflow <= 1'b0;
  ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .wr_en(wr),
    .din(frame[8:1]),
    .rd_en(pop),
    .dout(data),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames with a scoreboard checking popped scan codes
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TO = 200;
  logic clk = 0, resetn = 0, ps2_clk = 1, ps2_data = 1, nextdata_n = 1;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  int n_chk = 0, n_pass = 0;
  int fe_rise = 0, fe_hi = 0;
  logic fe_prev = 0;
  logic rdy_pre, rdy_post;
  logic [7:0] sb [$];

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitor: a pop will happen at the next edge, head must match
  always @(negedge clk) begin
    if (resetn && !nextdata_n && ready) begin
      if (sb.size() == 0) check("pop_unexpected", 32'(data), 32'hFFFF);
      else check("pop_data", 32'(data), 32'(sb.pop_front()));
    end
    if (frame_err) fe_hi++;
    if (frame_err && !fe_prev) fe_rise++;
    fe_prev = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(2);
      ps2_clk = 0;
      tick(2);
      rdy_pre = ready;
      if (pop_last && i == n - 1) nextdata_n = 0;
      tick(1);
      rdy_post = ready;
      nextdata_n = 1;
      tick(3);
      ps2_clk = 1;
      tick(2);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit push_exp, input bit pop_last);
    send_bits(mk(b, 0, 0), 11, pop_last);
    if (push_exp) sb.push_back(b);
  endtask

  task automatic pop_one();
    nextdata_n = 0;
    tick(1);
    nextdata_n = 1;
  endtask

  task automatic do_reset();
    resetn = 0;
    ps2_clk = 1;
    ps2_data = 1;
    tick(3);
    resetn = 1;
    tick(1);
  endtask

  initial begin
    tick(1);
    do_reset();
    check("rst_ready", 32'(ready), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_data", 32'(data), 0);
    pop_one();
    check("pop_empty_ready", 32'(ready), 0);
    check("pop_empty_ovf", 32'(overflow), 0);

    send(8'h1C, 1, 0);
    check("lat_pre", 32'(rdy_pre), 0);
    check("lat_post", 32'(rdy_post), 1);
    check("single_data", 32'(data), 32'h1C);
    pop_one();
    check("single_empty", 32'(ready), 0);

    send(8'hF0, 1, 0);
    send(8'h1C, 1, 0);
    check("two_ready", 32'(ready), 1);
    pop_one();
    check("two_ready_mid", 32'(ready), 1);
    pop_one();
    check("two_empty", 32'(ready), 0);

    send_bits(mk(8'h1C, 1, 0), 11, 0);
    send_bits(mk(8'h55, 0, 1), 11, 0);
    tick(2);
    check("ferr_pulses", 32'(fe_rise), 2);
    check("ferr_width", 32'(fe_hi), 2);
    check("ferr_ready", 32'(ready), 0);

    send_bits(mk(8'hAA, 0, 0), 5, 0);
    tick(TO + 1);
    send(8'h32, 1, 0);
    check("to_ready", 32'(ready), 1);
    check("to_data", 32'(data), 32'h32);
    check("to_no_ferr", 32'(fe_rise), 2);
    pop_one();

    send_bits(mk(8'h77, 0, 0), 4, 0);
    do_reset();
    send(8'h5A, 1, 0);
    check("midrst_data", 32'(data), 32'h5A);
    check("midrst_no_ferr", 32'(fe_rise), 2);
    pop_one();

    for (int i = 1; i <= 9; i++) send(8'(i), i <= 8, 0);
    check("ovf_set", 32'(overflow), 1);
    pop_one();
    check("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) pop_one();
    check("ovf_drained", 32'(ready), 0);

    for (int i = 1; i <= 8; i++) send(8'h10 + 8'(i), 1, 0);
    send(8'h19, 1, 1);
    check("fullpop_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      check("fullpop_ready", 32'(ready), 1);
      pop_one();
    end
    check("fullpop_empty", 32'(ready), 0);
    check("sb_empty", 32'(sb.size()), 0);
    check("ferr_total", 32'(fe_rise), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer entries; legal values are powers of two from 2 to 16.
- REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the clk cycles without a PS/2 falling edge before a partial frame is abandoned.
- REQ-003 SHALL have port clk, input, 1 bit: system clock; one clock domain, all logic on the rising edge.
- REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
- REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clk.
- REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data line.
- REQ-007 SHALL have port nextdata_n, input, 1 bit: pop request, active-low, sampled on each clk edge.
- REQ-008 SHALL have port data, output, 8 bits: the scan code at the FIFO head.
- REQ-009 SHALL have port ready, output, 1 bit: high when the FIFO is non-empty.
- REQ-010 SHALL have port overflow, output, 1 bit: sticky flag meaning a byte was dropped because the FIFO was full.
- REQ-011 SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a frame is rejected.

Function
- REQ-012 SHALL pass ps2_clk through a 3-flop synchronizer; a falling edge is detected when the two oldest stages read 1 then 0.
- REQ-013 SHALL sample ps2_data on the detected falling edge into an 11-bit shift register, LSB first, and advance a bit counter 0..10.
- REQ-014 SHALL check the frame when the 11th bit is sampled; a frame is valid when start=0, stop=1 and the 8 data bits plus the parity bit have odd parity.
- REQ-015 SHALL, for a valid frame with the FIFO not full, write the data byte into the FIFO; ready and data reflect it on the next clk cycle.
- REQ-016 SHALL, for a valid frame with the FIFO full and no pop in the same cycle, drop the byte and set overflow.
- REQ-017 SHALL, for an invalid frame, discard the byte, pulse frame_err high for exactly one cycle and leave the FIFO unchanged.
- REQ-018 SHALL return the bit counter to 0 after every 11th bit, whether the frame was valid or not.
- REQ-019 SHALL reset the bit counter to 0 without a frame_err pulse when the bit counter is non-zero and TIMEOUT_CYC cycles pass with no falling edge.
- REQ-020 SHALL drive data combinationally from the entry at the read pointer; data is don't-care while ready=0.
- REQ-021 SHALL, on nextdata_n=0 with ready=1, advance the read pointer by one per cycle; holding nextdata_n low pops one entry per cycle.
- REQ-022 SHALL ignore nextdata_n=0 while ready=0; pointers do not move and no flag changes.
- REQ-023 SHALL perform both operations when a write and a pop occur in the same cycle; when full, this does not set overflow and the count is unchanged.
- REQ-024 SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; empty = pointers equal, full = MSBs differ and the rest are equal.
- REQ-025 SHALL clear overflow on the first successful pop after it is set; a simultaneous set and clear resolves to set.

Reset
- REQ-026 SHALL, with resetn=0 at a clk edge, set pointers to 0, bit counter to 0, timeout counter to 0, synchronizer to 3'b111, ready=0, overflow=0, frame_err=0, and data reads 8'h00.
- REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; the first falling edge after release is treated as a start bit.

Structure
- REQ-028 SHALL place the frame length (11), the start/stop bit values and the default parameter values in the shared package ps2_pkg.
- REQ-029 SHALL implement the buffer as one sub-module, ps2_fifo, containing the storage, pointers and full/empty logic; the frame receiver stays in ps2_rx_fifo.

Verification
- REQ-030 SHALL cover a single frame for 8'h1C (keyboard 'A', parity=0) -> ready=1 one cycle after the stop-bit edge, data=8'h1C; a nextdata_n pulse then gives ready=0.
- REQ-031 SHALL cover frames 8'hF0, 8'h1C sent back-to-back with no pops -> two entries; successive pops return F0 then 1C.
- REQ-032 SHALL cover 9 valid frames with FIFO_DEPTH=8 and no pops -> overflow=1 after the 9th; the pops return frames 1..8 in order; overflow=0 after the first pop.
- REQ-033 SHALL cover a frame with a wrong parity bit, and another with stop=0 -> one frame_err pulse each, ready stays 0.
- REQ-034 SHALL cover sending 5 bits then idling TIMEOUT_CYC+1 cycles, then a full frame 8'h32 -> data=8'h32, no frame_err.
- REQ-035 SHALL cover FIFO full, a pop held in the same cycle the 9th frame completes -> overflow stays 0, the count stays 8, and the newest byte is last out.
